// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_INST = 1'b0,
        GRANT_DATA = 1'b1
    } grant_e;

    localparam int unsigned CNT_W = 4;

    // A tie goes to the favoured requester; otherwise whoever is asking wins.
    function automatic grant_e pick_grant(input logic inst_req, input logic data_req,
                                          input grant_e favoured);
        if (inst_req && data_req) begin
            return favoured;
        end
        return data_req ? GRANT_DATA : GRANT_INST;
    endfunction

endpackage

// File: rtl/arb_latency_counter.sv
// Down-counter timing the memory access phase; last_o flags the final access cycle.
module arb_latency_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic         last_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign last_o = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data access onto one fixed-latency memory port.
// Define ROUND_ROBIN_EN to alternate on ties; otherwise data wins ties.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    arb_state_e        state_q;
    grant_e            grant_q;
    grant_e            grant_d;
    grant_e            favoured;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              valid_q;
    logic              i_done_q;
    logic              d_done_q;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_last;

`ifdef ROUND_ROBIN_EN
    grant_e rr_q;  // requester favoured on the next tie

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= GRANT_INST;
        end else if (cnt_load) begin
            rr_q <= (grant_d == GRANT_INST) ? GRANT_DATA : GRANT_INST;
        end
    end

    assign favoured = rr_q;
`else
    assign favoured = GRANT_DATA;
`endif

    assign grant_d  = pick_grant(i_req, d_req, favoured);
    assign cnt_load = (state_q == ST_IDLE) && (i_req || d_req);
    assign cnt_dec  = (state_q == ST_BUSY) && !cnt_last;

    arb_latency_counter #(.W(CNT_W)) u_latency_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (LOAD_VAL),
        .last_o     (cnt_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= GRANT_INST;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            valid_q   <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        grant_q <= grant_d;
                        addr_q  <= (grant_d == GRANT_DATA) ? d_addr : i_addr;
                        we_q    <= (grant_d == GRANT_DATA) && d_we;
                        wdata_q <= (grant_d == GRANT_DATA) ? d_wdata : '0;
                        valid_q <= 1'b1;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_last) begin
                        valid_q <= 1'b0;
                        if (grant_q == GRANT_INST) begin
                            i_rdata_q <= mem_rdata;
                            i_done_q  <= 1'b1;
                        end else begin
                            // Stores keep the previous load result visible.
                            if (!we_q) begin
                                d_rdata_q <= mem_rdata;
                            end
                            d_done_q <= 1'b1;
                        end
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_valid = valid_q;
    assign mem_we    = valid_q & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timing model checked every cycle plus directed
// scenarios with literal expectations. Honours ROUND_ROBIN_EN like the design.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int L  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          i_done, d_done, mem_valid, mem_we;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(L)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a transaction sampled at edge e is busy after edges e..e+L-1, done after
    // edge e+L (capturing the read data present before that edge), and the next request
    // can only be sampled at edge e+L+2.
    int            edge_n = 0;
    int            t_start = -100;
    int            busy_until = 0;
    logic          m_g = 1'b0;       // 0 = instruction, 1 = data
    logic          m_fav = 1'b0;     // requester favoured on a tie
    logic [AW-1:0] m_addr = '0;
    logic          m_we = 1'b0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_i_rdata = '0;
    logic [DW-1:0] m_d_rdata = '0;
    logic          mgr[$];

    task automatic model_reset();
        t_start    = -100;
        busy_until = edge_n;
        m_i_rdata  = '0;
        m_d_rdata  = '0;
        m_fav      = 1'b0;
        m_we       = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        if (!reset) begin
            edge_n++;
            if (edge_n == t_start + L) begin
                if (!m_g) m_i_rdata = mem_rdata;
                else if (!m_we) m_d_rdata = mem_rdata;
            end
            if (edge_n > busy_until && (i_req || d_req)) begin
                if (i_req && d_req) begin
`ifdef ROUND_ROBIN_EN
                    m_g = m_fav;
`else
                    m_g = 1'b1;
`endif
                end else begin
                    m_g = d_req;
                end
                m_fav      = ~m_g;
                m_addr     = m_g ? d_addr : i_addr;
                m_we       = m_g & d_we;
                m_wdata    = m_g ? d_wdata : '0;
                t_start    = edge_n;
                busy_until = edge_n + L + 1;
                mgr.push_back(m_g);
            end
        end
    end

    initial forever begin
        bit busy;
        bit done;
        @(negedge clk);
        if (!reset) begin
            busy = (edge_n >= t_start) && (edge_n <= t_start + L - 1);
            done = (edge_n == t_start + L);
            check("cyc mem_valid", mem_valid, busy);
            check("cyc mem_we", mem_we, busy & m_we);
            if (busy) begin
                check("cyc mem_addr", mem_addr, m_addr);
                if (m_we) check("cyc mem_wdata", mem_wdata, m_wdata);
            end
            check("cyc i_done", i_done, done & !m_g);
            check("cyc d_done", d_done, done & m_g);
            check("cyc i_rdata", i_rdata, m_i_rdata);
            check("cyc d_rdata", d_rdata, m_d_rdata);
        end
    end

    // Waits (bounded) for the wanted done pulse; counts busy/write cycles and foreign dones.
    task automatic wait_done(input bit want_data, output int lat, output int vcnt,
                             output int other, output int wcnt, output logic [AW-1:0] last_addr);
        lat = -1; vcnt = 0; other = 0; wcnt = 0; last_addr = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mem_valid) begin
                vcnt++;
                last_addr = mem_addr;
            end
            if (mem_we && mem_wdata == d_wdata) wcnt++;
            if (want_data ? i_done : d_done) other++;
            if (want_data ? d_done : i_done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        int            lat, vc, od, wc, dn;
        logic [AW-1:0] la;
        logic          dq[$];
        int            dc[$];
        logic          exp_seq[4];

        i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset mem_valid", mem_valid, 0);
        check("reset mem_we", mem_we, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset i_done", i_done, 0);
        check("reset d_done", d_done, 0);
        check("reset i_rdata", i_rdata, 0);
        check("reset d_rdata", d_rdata, 0);
        reset = 1'b0;
        @(negedge clk);

        // Fetch 0x100 returning DEADBEEF
        i_addr = 32'h100; mem_rdata = 32'hDEADBEEF; i_req = 1;
        wait_done(0, lat, vc, od, wc, la);
        i_req = 0;
        $display("fetch: latency=%0d valid_cycles=%0d i_rdata=0x%0h", lat, vc, i_rdata);
        check("fetch latency", lat, 5);
        check("fetch valid cycles", vc, 4);
        check("fetch addr", la, 32'h100);
        check("fetch i_rdata", i_rdata, 32'hDEADBEEF);
        check("model fetch data", m_i_rdata, 32'hDEADBEEF);
        @(negedge clk);

        // Store 0x1234 to 0x40
        d_addr = 32'h40; d_wdata = 32'h1234; d_we = 1; mem_rdata = 32'h55555555; d_req = 1;
        wait_done(1, lat, vc, od, wc, la);
        d_req = 0; d_we = 0;
        $display("store: latency=%0d valid_cycles=%0d we_cycles=%0d i_dones=%0d", lat, vc, wc, od);
        check("store latency", lat, 5);
        check("store we cycles", wc, 4);
        check("store i_done count", od, 0);
        check("store d_rdata kept", d_rdata, 0);
        @(negedge clk);

        // Load from 0x40, request dropped and address changed after one busy cycle
        d_addr = 32'h40; mem_rdata = 32'hCAFEF00D; d_req = 1;
        @(negedge clk);
        d_req = 0; d_addr = 32'h80;
        wait_done(1, lat, vc, od, wc, la);
        $display("dropped load: latency=%0d last_addr=0x%0h d_rdata=0x%0h", lat, la, d_rdata);
        check("drop load remaining latency", lat, 4);
        check("drop load addr", la, 32'h40);
        check("drop load d_rdata", d_rdata, 32'hCAFEF00D);
        @(negedge clk);

        // Contention from a fresh reset: both requesters keep re-requesting
        pulse_reset();
        check("post reset i_rdata", i_rdata, 0);
        mgr.delete();
        i_addr = 32'h200; d_addr = 32'h300; d_we = 0; i_req = 1; d_req = 1;
        for (int k = 1; k <= 100 && dq.size() < 4; k++) begin
            @(negedge clk);
            mem_rdata = $urandom;
            if (i_done) begin dq.push_back(1'b0); dc.push_back(k); end
            if (d_done) begin dq.push_back(1'b1); dc.push_back(k); end
            i_req = !i_done;
            d_req = !d_done;
        end
        i_req = 0; d_req = 0;
`ifdef ROUND_ROBIN_EN
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        check("contention done count", dq.size(), 4);
        check("model grant count", mgr.size(), 4);
        for (int n = 0; n < 4; n++) begin
            if (n < dq.size()) begin
                $display("contention txn %0d: grant=%s at cycle %0d", n, dq[n] ? "DATA" : "INST", dc[n]);
                check("contention grant order", dq[n], exp_seq[n]);
                if (n > 0) check("contention spacing", dc[n] - dc[n-1], L + 2);
            end
            if (n < mgr.size()) check("model grant order", mgr[n], exp_seq[n]);
        end
        if (dc.size() > 0) check("contention first done", dc[0], 5);
        @(negedge clk);

        // Reset in the second busy cycle aborts the fetch silently
        i_addr = 32'h100; i_req = 1;
        @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        $display("mid reset: mem_valid=%0b i_done=%0b", mem_valid, i_done);
        check("mid reset mem_valid", mem_valid, 0);
        check("mid reset i_done", i_done, 0);
        @(negedge clk);
        reset = 1'b0; i_req = 0;
        dn = 0;
        repeat (8) begin
            @(negedge clk);
            if (i_done || d_done) dn++;
        end
        check("aborted done pulses", dn, 0);
        mem_rdata = 32'h0BADF00D; i_req = 1;
        wait_done(0, lat, vc, od, wc, la);
        i_req = 0;
        $display("fresh fetch: latency=%0d valid_cycles=%0d i_rdata=0x%0h", lat, vc, i_rdata);
        check("fresh fetch latency", lat, 5);
        check("fresh fetch valid cycles", vc, 4);
        check("fresh fetch i_rdata", i_rdata, 32'h0BADF00D);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
